// File: rtl/wb_arbiter_2to1_if.sv
// Single-transaction Wishbone bus bundle shared by the arbiter's master and slave ports.
interface wb_bus;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        stb;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output addr, output wdata, output we, output stb,
                  input rdata, input ack, input err);
  modport slave  (input addr, input wdata, input we, input stb,
                  output rdata, output ack, output err);
endinterface

// File: rtl/wb_arbiter_2to1.sv
// Two-master Wishbone arbiter: round-robin grant of single transactions onto one slave,
// masking stray registered acks between transactions and timing out a silent slave.
module wb_arbiter_2to1 #(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic  clk_in,
  input  logic  reset_in,
  wb_bus.slave  m0_bus,
  wb_bus.slave  m1_bus,
  wb_bus.master s_bus
);
  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            last, last_nxt;
  logic [CntW-1:0] cnt, cnt_nxt;
  logic            busy, sel, req_stb;
  logic            fwd_ack, fwd_err;

  assign busy    = (state != IDLE);
  assign sel     = (state == BUSY1);
  assign req_stb = sel ? m1_bus.stb : m0_bus.stb;

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Grant selection and transaction termination; terminations always pass through IDLE.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    fwd_ack   = 1'b0;
    fwd_err   = 1'b0;
    case (state)
      IDLE: begin
        if (m0_bus.stb && (!m1_bus.stb || last)) begin
          state_nxt = BUSY0;
          last_nxt  = 1'b0;
          cnt_nxt   = '0;
        end else if (m1_bus.stb) begin
          state_nxt = BUSY1;
          last_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      BUSY0, BUSY1: begin
        if (s_bus.err) begin
          fwd_err   = 1'b1;
          state_nxt = IDLE;
        end else if (s_bus.ack) begin
          fwd_ack   = 1'b1;
          state_nxt = IDLE;
        end else if (!req_stb) begin
          state_nxt = IDLE;
        end else if (cnt == CntLast) begin
          fwd_err   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt != CntMax) begin
          cnt_nxt = cnt + CntW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus steering: slave sees only the granted master, responses reach only that master.
  always_comb begin
    s_bus.addr   = busy ? (sel ? m1_bus.addr  : m0_bus.addr)  : 32'h0;
    s_bus.wdata  = busy ? (sel ? m1_bus.wdata : m0_bus.wdata) : 32'h0;
    s_bus.we     = busy & (sel ? m1_bus.we : m0_bus.we);
    s_bus.stb    = busy & req_stb;
    m0_bus.ack   = busy & ~sel & fwd_ack;
    m0_bus.err   = busy & ~sel & fwd_err;
    m0_bus.rdata = (busy && !sel) ? s_bus.rdata : 32'h0;
    m1_bus.ack   = sel & fwd_ack;
    m1_bus.err   = sel & fwd_err;
    m1_bus.rdata = sel ? s_bus.rdata : 32'h0;
  end
endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// Bench for wb_arbiter_2to1: program-memory slave model plus a response scoreboard.
module tb_wb_arbiter_2to1;
  typedef struct packed {
    logic        master;
    logic        is_err;
    logic [31:0] rdata;
  } resp_t;

  logic clk_in = 1'b0;
  logic reset_in;
  int   checks = 0;
  int   errors = 0;
  resp_t sb[$];

  wb_bus m0_bus ();
  wb_bus m1_bus ();
  wb_bus s_bus ();

  wb_arbiter_2to1 #(.TimeoutCycles(16)) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .m0_bus  (m0_bus),
    .m1_bus  (m1_bus),
    .s_bus   (s_bus)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0012_8293 ^ {a[15:0], 16'h0000};
  endfunction

  function automatic resp_t mk_resp(input logic m, input logic e, input logic [31:0] d);
    resp_t r;
    r.master = m;
    r.is_err = e;
    r.rdata  = d;
    return r;
  endfunction

  // Program memory: registered ack/rdata, rejects writes with a combinational err.
  logic        slave_silent, inject_ack, s_ack_q;
  logic [31:0] s_rdata_q;
  always_ff @(posedge clk_in) begin
    s_ack_q   <= s_bus.stb && !s_bus.we && !slave_silent;
    s_rdata_q <= mem_word(s_bus.addr);
  end
  assign s_bus.ack   = s_ack_q | inject_ack;
  assign s_bus.err   = s_bus.stb & s_bus.we & ~slave_silent;
  assign s_bus.rdata = s_rdata_q;

  // Every master-side response must match the next scoreboard entry.
  logic        mon_ack, mon_err;
  logic [31:0] mon_rdata;
  resp_t       mon_exp;
  always @(negedge clk_in) begin
    for (int m = 0; m < 2; m++) begin
      mon_ack   = (m == 1) ? m1_bus.ack   : m0_bus.ack;
      mon_err   = (m == 1) ? m1_bus.err   : m0_bus.err;
      mon_rdata = (m == 1) ? m1_bus.rdata : m0_bus.rdata;
      if (mon_ack || mon_err) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_m%0d: got ack=%0b err=%0b, required no response",
                   m, mon_ack, mon_err);
        end else begin
          mon_exp = sb.pop_front();
          if (int'(mon_exp.master) != m || mon_exp.is_err !== mon_err ||
              mon_exp.is_err === mon_ack || (mon_ack && mon_rdata !== mon_exp.rdata)) begin
            errors++;
            $display("FAIL sb_resp: got m%0d ack=%0b err=%0b rdata=%08h, required m%0d err=%0b rdata=%08h",
                     m, mon_ack, mon_err, mon_rdata, mon_exp.master, mon_exp.is_err, mon_exp.rdata);
          end
        end
      end
    end
  end

  task automatic clear_masters();
    m0_bus.stb = 1'b0; m0_bus.we = 1'b0; m0_bus.addr = 32'h0; m0_bus.wdata = 32'h0;
    m1_bus.stb = 1'b0; m1_bus.we = 1'b0; m1_bus.addr = 32'h0; m1_bus.wdata = 32'h0;
  endtask

  // Leaves the caller in cycle 0: the next rising edge is the first one out of reset.
  task automatic do_reset();
    reset_in = 1'b0;
    clear_masters();
    inject_ack = 1'b0;
    slave_silent = 1'b0;
    repeat (2) @(negedge clk_in);
    #1 reset_in = 1'b1;
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    clear_masters();
    inject_ack = 1'b0;
    slave_silent = 1'b0;
    m0_bus.stb = 1'b1; m0_bus.addr = 32'h20; m1_bus.stb = 1'b1; m1_bus.addr = 32'h24;
    repeat (2) @(negedge clk_in);
    checks++;
    if (s_bus.stb !== 1'b0 || s_bus.addr !== 32'h0 || s_bus.wdata !== 32'h0 || s_bus.we !== 1'b0) begin
      errors++;
      $display("FAIL reset_slave_side: stb=%0b addr=%08h wdata=%08h we=%0b, required all 0",
               s_bus.stb, s_bus.addr, s_bus.wdata, s_bus.we);
    end
    checks++;
    if (m0_bus.ack !== 1'b0 || m0_bus.err !== 1'b0 || m0_bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_m0: ack=%0b err=%0b rdata=%08h, required all 0",
               m0_bus.ack, m0_bus.err, m0_bus.rdata);
    end
    checks++;
    if (m1_bus.ack !== 1'b0 || m1_bus.err !== 1'b0 || m1_bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_m1: ack=%0b err=%0b rdata=%08h, required all 0",
               m1_bus.ack, m1_bus.err, m1_bus.rdata);
    end
  endtask

  task automatic test_single_read();
    logic drop0 = 1'b0;
    do_reset();
    m0_bus.addr = 32'h0; m0_bus.stb = 1'b1;
    sb.push_back(mk_resp(1'b0, 1'b0, 32'h0012_8293));
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk_in); #1;
      if (drop0) m0_bus.stb = 1'b0;
      @(negedge clk_in);
      checks++;
      if (s_bus.stb !== 1'(n == 1 || n == 2)) begin
        errors++;
        $display("FAIL single_s_stb c%0d: got %0b, required %0b", n, s_bus.stb, (n == 1 || n == 2));
      end
      checks++;
      if (m0_bus.ack !== 1'(n == 2) || m1_bus.ack !== 1'b0) begin
        errors++;
        $display("FAIL single_ack c%0d: got m0=%0b m1=%0b, required m0=%0b m1=0",
                 n, m0_bus.ack, m1_bus.ack, (n == 2));
      end
      if (n == 2) begin
        checks++;
        if (m0_bus.rdata !== 32'h0012_8293) begin
          errors++;
          $display("FAIL single_rdata: got %08h, required 00128293", m0_bus.rdata);
        end
      end
      if (n == 3) begin
        checks++;
        if (m0_bus.rdata !== 32'h0) begin
          errors++;
          $display("FAIL single_idle_rdata: got %08h, required 00000000", m0_bus.rdata);
        end
      end
      if (m0_bus.ack) drop0 = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    logic drop0 = 1'b0, drop1 = 1'b0;
    int n0 = 0, n1 = 0;
    do_reset();
    m0_bus.addr = 32'h0; m1_bus.addr = 32'h8;
    m0_bus.stb = 1'b1; m1_bus.stb = 1'b1;
    sb.push_back(mk_resp(1'b0, 1'b0, mem_word(32'h0)));
    sb.push_back(mk_resp(1'b1, 1'b0, mem_word(32'h8)));
    sb.push_back(mk_resp(1'b0, 1'b0, mem_word(32'h0)));
    sb.push_back(mk_resp(1'b1, 1'b0, mem_word(32'h8)));
    for (int n = 1; n <= 13; n++) begin
      @(posedge clk_in); #1;
      if (drop0) m0_bus.stb = 1'b0;
      if (drop1) m1_bus.stb = 1'b0;
      @(negedge clk_in);
      checks++;
      if (m0_bus.ack !== 1'(n == 2 || n == 8)) begin
        errors++;
        $display("FAIL rr_m0_ack c%0d: got %0b, required %0b", n, m0_bus.ack, (n == 2 || n == 8));
      end
      checks++;
      if (m1_bus.ack !== 1'(n == 5 || n == 11)) begin
        errors++;
        $display("FAIL rr_m1_ack c%0d: got %0b, required %0b", n, m1_bus.ack, (n == 5 || n == 11));
      end
      if (m0_bus.ack) begin n0++; if (n0 == 2) drop0 = 1'b1; end
      if (m1_bus.ack) begin n1++; if (n1 == 2) drop1 = 1'b1; end
    end
    checks++;
    if (n0 != 2 || n1 != 2) begin
      errors++;
      $display("FAIL rr_ack_count: got m0=%0d m1=%0d, required 2 and 2", n0, n1);
    end
  endtask

  task automatic test_error();
    logic drop1 = 1'b0;
    do_reset();
    m1_bus.we = 1'b1; m1_bus.addr = 32'h4; m1_bus.wdata = 32'hCAFE_0001; m1_bus.stb = 1'b1;
    sb.push_back(mk_resp(1'b1, 1'b1, 32'h0));
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk_in); #1;
      if (drop1) begin m1_bus.stb = 1'b0; m1_bus.we = 1'b0; end
      @(negedge clk_in);
      checks++;
      if (m1_bus.err !== 1'(n == 1) || m1_bus.ack !== 1'b0) begin
        errors++;
        $display("FAIL err_m1 c%0d: got err=%0b ack=%0b, required err=%0b ack=0",
                 n, m1_bus.err, m1_bus.ack, (n == 1));
      end
      checks++;
      if (m0_bus.err !== 1'b0 || m0_bus.ack !== 1'b0) begin
        errors++;
        $display("FAIL err_m0 c%0d: got err=%0b ack=%0b, required 0 0", n, m0_bus.err, m0_bus.ack);
      end
      if (n == 1) begin
        checks++;
        if (s_bus.we !== 1'b1 || s_bus.wdata !== 32'hCAFE_0001 || s_bus.addr !== 32'h4) begin
          errors++;
          $display("FAIL err_s_write: got we=%0b wdata=%08h addr=%08h, required 1 cafe0001 00000004",
                   s_bus.we, s_bus.wdata, s_bus.addr);
        end
      end
      if (m1_bus.err) drop1 = 1'b1;
    end
  endtask

  task automatic test_timeout();
    logic drop0 = 1'b0;
    do_reset();
    slave_silent = 1'b1;
    m0_bus.addr = 32'h10; m1_bus.addr = 32'h18; m0_bus.stb = 1'b1;
    sb.push_back(mk_resp(1'b0, 1'b1, 32'h0));
    for (int n = 1; n <= 18; n++) begin
      @(posedge clk_in); #1;
      if (drop0) begin m0_bus.stb = 1'b0; m1_bus.stb = 1'b1; drop0 = 1'b0; end
      @(negedge clk_in);
      checks++;
      if (m0_bus.err !== 1'(n == 16)) begin
        errors++;
        $display("FAIL timeout_err c%0d: got %0b, required %0b", n, m0_bus.err, (n == 16));
      end
      checks++;
      if (s_bus.stb !== 1'(n <= 16 || n == 18)) begin
        errors++;
        $display("FAIL timeout_s_stb c%0d: got %0b, required %0b", n, s_bus.stb, (n <= 16 || n == 18));
      end
      if (n == 18) begin
        checks++;
        if (s_bus.addr !== 32'h18) begin
          errors++;
          $display("FAIL timeout_next_grant: got addr=%08h, required 00000018", s_bus.addr);
        end
      end
      if (m0_bus.err) drop0 = 1'b1;
    end
    @(posedge clk_in); #1 m1_bus.stb = 1'b0;
    @(posedge clk_in); #1 slave_silent = 1'b0;
  endtask

  task automatic test_abort();
    do_reset();
    m0_bus.addr = 32'hC; m1_bus.addr = 32'h8; m0_bus.stb = 1'b1;
    @(posedge clk_in); #1 m0_bus.stb = 1'b0;
    @(negedge clk_in);
    checks++;
    if (s_bus.stb !== 1'b0 || m0_bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_c1: got s_stb=%0b m0_ack=%0b, required 0 0", s_bus.stb, m0_bus.ack);
    end
    @(posedge clk_in); #1 inject_ack = 1'b1;
    @(negedge clk_in);
    checks++;
    if (m0_bus.ack !== 1'b0 || m0_bus.err !== 1'b0 || m1_bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_stray: got m0 ack=%0b err=%0b m1 ack=%0b, required all 0",
               m0_bus.ack, m0_bus.err, m1_bus.ack);
    end
    @(posedge clk_in); #1 inject_ack = 1'b0;
    @(negedge clk_in);
    #1 m0_bus.stb = 1'b1; m1_bus.stb = 1'b1;
    sb.push_back(mk_resp(1'b1, 1'b0, mem_word(32'h8)));
    @(negedge clk_in);
    checks++;
    if (s_bus.stb !== 1'b1 || s_bus.addr !== 32'h8) begin
      errors++;
      $display("FAIL abort_rr_tie: got stb=%0b addr=%08h, required 1 00000008", s_bus.stb, s_bus.addr);
    end
    #1 m0_bus.stb = 1'b0;
    @(negedge clk_in);
    checks++;
    if (m1_bus.ack !== 1'b1) begin
      errors++;
      $display("FAIL abort_rr_ack: got %0b, required 1", m1_bus.ack);
    end
    @(posedge clk_in); #1 m1_bus.stb = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic drop0 = 1'b0, drop1 = 1'b0;
    do_reset();
    m1_bus.addr = 32'h8; m1_bus.stb = 1'b1;
    @(posedge clk_in); #1;
    m0_bus.addr = 32'h14; m0_bus.stb = 1'b1; reset_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if (s_bus.stb !== 1'b1 || s_bus.addr !== 32'h8) begin
      errors++;
      $display("FAIL rst_busy1: got stb=%0b addr=%08h, required 1 00000008", s_bus.stb, s_bus.addr);
    end
    @(posedge clk_in); #1 reset_in = 1'b1;
    @(negedge clk_in);
    checks++;
    if (s_bus.stb !== 1'b0 || s_bus.addr !== 32'h0 || s_bus.we !== 1'b0 ||
        m0_bus.ack !== 1'b0 || m0_bus.err !== 1'b0 || m0_bus.rdata !== 32'h0 ||
        m1_bus.ack !== 1'b0 || m1_bus.err !== 1'b0 || m1_bus.rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_outputs: got s_stb=%0b s_addr=%08h m0 %0b%0b/%08h m1 %0b%0b/%08h, required all 0",
               s_bus.stb, s_bus.addr, m0_bus.ack, m0_bus.err, m0_bus.rdata,
               m1_bus.ack, m1_bus.err, m1_bus.rdata);
    end
    sb.push_back(mk_resp(1'b0, 1'b0, mem_word(32'h14)));
    sb.push_back(mk_resp(1'b1, 1'b0, mem_word(32'h8)));
    for (int n = 3; n <= 9; n++) begin
      @(posedge clk_in); #1;
      if (drop0) m0_bus.stb = 1'b0;
      if (drop1) m1_bus.stb = 1'b0;
      @(negedge clk_in);
      if (n == 3) begin
        checks++;
        if (s_bus.stb !== 1'b1 || s_bus.addr !== 32'h14) begin
          errors++;
          $display("FAIL rst_tie_m0: got stb=%0b addr=%08h, required 1 00000014", s_bus.stb, s_bus.addr);
        end
      end
      checks++;
      if (m0_bus.ack !== 1'(n == 4) || m1_bus.ack !== 1'(n == 7)) begin
        errors++;
        $display("FAIL rst_after_acks c%0d: got m0=%0b m1=%0b, required %0b %0b",
                 n, m0_bus.ack, m1_bus.ack, (n == 4), (n == 7));
      end
      if (m0_bus.ack) drop0 = 1'b1;
      if (m1_bus.ack) drop1 = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_error();
    test_timeout();
    test_abort();
    test_reset_mid();
    repeat (3) @(negedge clk_in);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
